// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
//   F3_*        : RV32 load/store width codes (funct3)
//   mem_state_t : access sequencer states
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Byte/halfword lane handling for RV32 loads and stores (combinational).
//   funct3      : width code of the access
//   is_store    : access is a store (BU/HU codes are illegal for stores)
//   addr        : low two bits of the byte address
//   store_data  : rs2 value to be stored
//   old_word    : current contents of the addressed word
//   read_word   : word read for a load
//   store_word  : old_word with the selected lanes replaced
//   load_value  : selected lane, sign/zero extended; 0 on error
//   misaligned  : misaligned address or illegal funct3
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] old_word,
    input  logic [31:0] read_word,
    output logic [31:0] store_word,
    output logic [31:0] load_value,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte  = read_word[{addr, 3'b000} +: 8];
        lane_half  = addr[1] ? read_word[31:16] : read_word[15:0];
        store_word = old_word;
        load_value = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_B: begin
                store_word[{addr, 3'b000} +: 8] = store_data[7:0];
                load_value = {{24{lane_byte[7]}}, lane_byte};
            end
            F3_BU: begin
                misaligned = is_store;
                load_value = {24'd0, lane_byte};
            end
            F3_H: begin
                misaligned = addr[0];
                if (addr[1]) store_word[31:16] = store_data[15:0];
                else         store_word[15:0]  = store_data[15:0];
                load_value = {{16{lane_half[15]}}, lane_half};
            end
            F3_HU: begin
                misaligned = is_store | addr[0];
                load_value = {16'd0, lane_half};
            end
            F3_W: begin
                misaligned = (addr != 2'b00);
                store_word = store_data;
                load_value = read_word;
            end
            default: misaligned = 1'b1;
        endcase
        if (misaligned) load_value = '0;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory responder with fixed access latency.
//   clk, reset           : clock, async active-low reset
//   mem_read, mem_write  : load / store request (both high = store)
//   funct3               : RV32 width code
//   address              : byte address, wraps modulo DEPTH words
//   write_data           : store data
//   read_data            : extended load result, held until next load
//   busywait             : pipeline stall, high from request to end of ACCESS
//   misaligned           : one-cycle error flag in DONE
//
// state  | meaning
// IDLE   | waiting for a request; busywait follows the request
// ACCESS | request latched, down-counting latency; array access at cnt==0
// DONE   | result valid, pipeline advances, never re-accepts
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busywait,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    mem_state_t     state;
    logic [CW-1:0]  cnt;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     f3_q;
    logic           store_q;

    logic [31:0]    mem [DEPTH];
    logic [31:0]    cur_word;
    logic [31:0]    store_word;
    logic [31:0]    load_value;
    logic           err;
    logic           access_now;

    // Address bits above the array size simply alias (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[31:AW+2];

    assign busywait   = (state == ACCESS) || ((state == IDLE) && (mem_read || mem_write));
    assign access_now = (state == ACCESS) && (cnt == '0);
    assign cur_word   = mem[addr_q[AW+1:2]];

    load_store_align u_align (
        .funct3     (f3_q),
        .is_store   (store_q),
        .addr       (addr_q[1:0]),
        .store_data (wdata_q),
        .old_word   (cur_word),
        .read_word  (cur_word),
        .store_word (store_word),
        .load_value (load_value),
        .misaligned (err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            store_q    <= 1'b0;
            read_data  <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= address[AW+1:0];
                        wdata_q <= write_data;
                        f3_q    <= funct3;
                        store_q <= mem_write;
                        cnt     <= CNT_INIT;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        if (err) begin
                            misaligned <= 1'b1;
                            read_data  <= '0;
                        end else if (!store_q) begin
                            read_data  <= load_value;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array is not reset; a reset mid-access returns state to IDLE so no write occurs.
    always_ff @(posedge clk) begin
        if (access_now && store_q && !err) mem[addr_q[AW+1:2]] <= store_word;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
    import mem_pkg::*;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 3;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busywait;
    logic        misaligned;

    int passed = 0;
    int total  = 0;

    data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .busywait   (busywait),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        chk_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_mis, input logic chk_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.chk_rd = chk_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One access from the current IDLE cycle. Returns the number of cycles
    // busywait was high and the DONE-cycle outputs. Inputs are scrambled after
    // the request edge unless hold is set.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rdata, output logic mis, output int nbusy);
        mem_read = rd; mem_write = wr; funct3 = f3; address = a; write_data = wd;
        nbusy = 0;
        @(negedge clk);
        while (busywait && nbusy < 50) begin
            nbusy++;
            @(posedge clk); #1;
            if (!hold) begin
                mem_read = 1'b0; mem_write = 1'b0;
                address = $urandom; write_data = $urandom; funct3 = 3'($urandom);
            end
            @(negedge clk);
        end
        rdata = read_data;
        mis   = misaligned;
        @(posedge clk); #1;
        if (!hold) begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
    endtask

    // Byte-addressed reference memory for the randomized phase.
    bit [7:0] ref_b [int unsigned];

    task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         inout logic [31:0] exp_rd, output logic exp_mis);
        int sz;
        bit st, sgn, ok;
        int unsigned base;
        longint v;
        st = wr;
        sz = 0;
        if (st) begin
            if (f3 == 3'd0) sz = 1; else if (f3 == 3'd1) sz = 2; else if (f3 == 3'd2) sz = 4;
        end else begin
            if (f3 == 3'd0 || f3 == 3'd4) sz = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) sz = 2;
            else if (f3 == 3'd2) sz = 4;
        end
        sgn  = !st && (f3 == 3'd0 || f3 == 3'd1);
        ok   = (sz != 0) && ((a % sz) == 0);
        base = a % (DEPTH * 4);
        exp_mis = !ok;
        if (!ok) begin
            exp_rd = 32'd0;
        end else if (st) begin
            for (int i = 0; i < sz; i++) ref_b[base + i] = 8'(wd >> (8 * i));
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v += longint'(ref_b[base + i]) << (8 * i);
            if (sgn && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
            exp_rd = 32'(v);
        end
    endtask

    logic [31:0] rd_v;
    logic        mis_v;
    int          nb;
    logic [31:0] exp_rd;
    logic        exp_mis;

    initial begin
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busywait", {31'd0, busywait}, 32'd0);
        chk("reset_read_data", read_data, 32'd0);
        chk("reset_misaligned", {31'd0, misaligned}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        vecs.push_back(mk(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 1, F3_W,  32'h10, 32'h11223344, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, F3_B,  32'h13, 32'h123456AA, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0, F3_W,  32'h10, 32'h0,        32'hAA223344, 0, 1));
        vecs.push_back(mk(1, 0, F3_B,  32'h13, 32'h0,        32'hFFFFFFAA, 0, 1));
        vecs.push_back(mk(1, 0, F3_BU, 32'h13, 32'h0,        32'h000000AA, 0, 1));
        vecs.push_back(mk(1, 0, F3_B,  32'h11, 32'h0,        32'h00000033, 0, 1));
        vecs.push_back(mk(0, 1, F3_W,  32'h20, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, F3_H,  32'h22, 32'h5A5A8001, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0, F3_H,  32'h22, 32'h0,        32'hFFFF8001, 0, 1));
        vecs.push_back(mk(1, 0, F3_HU, 32'h22, 32'h0,        32'h00008001, 0, 1));
        vecs.push_back(mk(1, 0, F3_W,  32'h20, 32'h0,        32'h80010000, 0, 1));
        vecs.push_back(mk(1, 0, F3_H,  32'h20, 32'h0,        32'h00000000, 0, 1));
        vecs.push_back(mk(0, 1, F3_W,  32'h00, 32'h01020304, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0, F3_W,  32'h05, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(1, 0, F3_W,  32'h00, 32'h0,        32'h01020304, 0, 1));
        vecs.push_back(mk(0, 1, F3_H,  32'h03, 32'h0000BEEF, 32'h0,        1, 1));
        vecs.push_back(mk(1, 0, F3_W,  32'h00, 32'h0,        32'h01020304, 0, 1));
        vecs.push_back(mk(1, 0, 3'b011, 32'h00, 32'h0,       32'h0,        1, 1));
        vecs.push_back(mk(1, 0, F3_W,  32'h00, 32'h0,        32'h01020304, 0, 1));
        vecs.push_back(mk(0, 1, 3'b011, 32'h00, 32'hFFFFFFFF, 32'h0,       1, 1));
        vecs.push_back(mk(0, 1, F3_BU, 32'h00, 32'hFFFFFFFF, 32'h0,        1, 1));
        vecs.push_back(mk(1, 0, F3_W,  32'h00, 32'h0,        32'h01020304, 0, 1));
        vecs.push_back(mk(1, 1, F3_W,  32'h30, 32'hCAFEF00D, 32'h01020304, 0, 1));
        vecs.push_back(mk(1, 0, F3_W,  32'h30, 32'h0,        32'hCAFEF00D, 0, 1));
        vecs.push_back(mk(1, 0, F3_W,  32'(DEPTH * 4 + 16), 32'h0, 32'hAA223344, 0, 1));
        vecs.push_back(mk(1, 0, F3_HU, 32'h12, 32'h0,        32'h0000AA22, 0, 1));

        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, 1'b0, rd_v, mis_v, nb);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(LATENCY + 1));
            chk($sformatf("vec%0d_misaligned", i), {31'd0, mis_v}, {31'd0, vecs[i].exp_mis});
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_read_data", i), rd_v, vecs[i].exp_rd);
        end

        // Request held across DONE: one access, next starts in the following IDLE
        access(0, 1, F3_W, 32'(DEPTH * 4 + 16), 32'h12345678, 1'b1, rd_v, mis_v, nb);
        chk("hold_first_busy_cycles", 32'(nb), 32'(LATENCY + 1));
        @(negedge clk);
        chk("hold_idle_busywait", {31'd0, busywait}, 32'd1);
        @(posedge clk); #1;
        // Still in IDLE before that edge, so a fresh full-length access follows.
        mem_read = 1'b0; mem_write = 1'b0;
        nb = 1;
        @(negedge clk);
        while (busywait && nb < 50) begin
            nb++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk("hold_second_busy_cycles", 32'(nb), 32'(LATENCY + 1));
        @(posedge clk); #1;
        access(1, 0, F3_W, 32'h10, 32'h0, 1'b0, rd_v, mis_v, nb);
        chk("alias_read_data", rd_v, 32'h12345678);

        // Reset in the second ACCESS cycle of a store
        mem_write = 1'b1; funct3 = F3_W; address = 32'h10; write_data = 32'h55555555;
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_busywait", {31'd0, busywait}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midreset_busywait", {31'd0, busywait}, 32'd0);
        chk("midreset_read_data", read_data, 32'd0);
        chk("midreset_misaligned", {31'd0, misaligned}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        access(1, 0, F3_W, 32'h10, 32'h0, 1'b0, rd_v, mis_v, nb);
        chk("midreset_word_unchanged", rd_v, 32'h12345678);

        // Randomized phase against the byte-level reference model
        exp_rd = rd_v;
        for (int w = 0; w < 16; w++) begin
            logic [31:0] val;
            val = $urandom;
            model(1'b0, 1'b1, F3_W, 32'h200 + 32'(4 * w), val, exp_rd, exp_mis);
            access(1'b0, 1'b1, F3_W, 32'h200 + 32'(4 * w), val, 1'b0, rd_v, mis_v, nb);
            chk("init_busy_cycles", 32'(nb), 32'(LATENCY + 1));
        end
        for (int n = 0; n < 300; n++) begin
            int op;
            logic rd, wr;
            logic [2:0] f3;
            logic [31:0] a, wd;
            op = $urandom_range(0, 2);
            rd = (op != 1);
            wr = (op != 0);
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h200 + 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3) * DEPTH * 4);
            wd = $urandom;
            model(rd, wr, f3, a, wd, exp_rd, exp_mis);
            access(rd, wr, f3, a, wd, 1'b0, rd_v, mis_v, nb);
            chk($sformatf("rand%0d_busy_cycles", n), 32'(nb), 32'(LATENCY + 1));
            chk($sformatf("rand%0d_misaligned", n), {31'd0, mis_v}, {31'd0, exp_mis});
            chk($sformatf("rand%0d_read_data", n), rd_v, exp_rd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the MEM stage of the RV32IM pipeline. It serves the load/store requests that the EX/MEM pipeline register presents (read/write strobes, ALU-computed address, rs2 store data) from a word-organised on-chip array. It models a fixed access latency and holds `busywait` high until the access completes, which stalls the pipeline registers. It also performs RV32 byte/halfword lane selection and load sign/zero extension.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array; power of two.
- `LATENCY`, 3: cycles spent in ACCESS per request; legal range ≥1.
- `clk` input 1: single clock, rising-edge active.
- `reset` input 1: asynchronous, active-low reset.
- `mem_read` input 1: load request from EX/MEM.
- `mem_write` input 1: store request from EX/MEM.
- `funct3` input 3: RV32 load/store width code.
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store data (rs2 value).
- `read_data` output 32: extended load result; valid in DONE, held until the next load completes.
- `busywait` output 1: stall request to all pipeline registers.
- `misaligned` output 1: one-cycle error flag in DONE for a misaligned or illegal access.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On `mem_read|mem_write`, `busywait` asserts combinationally in the same cycle.
  - At the next edge, latch `address`, `write_data`, `funct3` and the op, load `cnt = LATENCY-1`, and go to ACCESS.
- ACCESS:
  - `busywait` = 1; `cnt` decrements each edge.
  - At the edge where `cnt == 0`, perform the array access and go to DONE.
- DONE:
  - `busywait` = 0; `read_data` and `misaligned` are valid.
  - The next edge always returns to IDLE. A request still asserted in DONE is not re-accepted, because the pipeline advances on that edge.
- Word index = `address[log2(DEPTH)+1:2]`. Addresses beyond DEPTH wrap modulo DEPTH words.
- Loads:
  - funct3 000 LB and 100 LBU select the byte lane `address[1:0]`.
  - 001 LH and 101 LHU select the half given by `address[1]`.
  - 010 LW returns the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - 000 SB writes the low byte of `write_data` into lane `address[1:0]`.
  - 001 SH writes the low half into half `address[1]`.
  - 010 SW writes the full word.
  - Unselected bytes are unchanged.
- Error cases: a halfword access with `address[0]=1`, a word access with `address[1:0]!=0`, or any other funct3 value.
  - Nothing is written; `read_data` is set to 0.
  - `misaligned` = 1 for the DONE cycle.
- `mem_read` and `mem_write` both high: treated as a store.
- Inputs changing or dropping during ACCESS are ignored; the latched request completes.

## Timing
- Reset values: state IDLE, `busywait` 0, `read_data` 0, `misaligned` 0, `cnt` 0. Array contents are not reset.
- Reset asserted mid-access: the access is abandoned, no write occurs, outputs return to their reset values immediately.
- Request first seen in cycle 0:
  - `busywait` high in cycles 0 through LATENCY.
  - DONE is cycle LATENCY+1.
  - Each access costs LATENCY+2 cycles.
- Back-to-back requests: the next request is sampled in the IDLE cycle after DONE. There is no overlap.
- A store is visible to a load that completes after it.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - FSM state typedef `mem_state_t` (IDLE, ACCESS, DONE).
- Sub-module `load_store_align`, purely combinational:
  - Inputs: funct3, `addr[1:0]`, store data, old word, read word.
  - Outputs: merged store word, extended load value, misaligned flag.
- The top level holds the FSM, counter, request latches and array.

## Test plan
- LATENCY=3: SW 0xDEADBEEF to 0x10, then LW 0x10.
  - `busywait` high 4 cycles per access; `read_data` = 0xDEADBEEF in DONE.
- SB 0xAA to 0x13 over word 0x11223344, then LB 0x13 and LBU 0x13.
  - Word reads 0xAA223344; LB returns 0xFFFFFFAA; LBU returns 0x000000AA.
- SH 0x8001 to 0x22, then LH 0x22 and LHU 0x22.
  - LH returns 0xFFFF8001; LHU returns 0x00008001.
- LW at 0x05, SH at 0x03, funct3 011.
  - `misaligned` pulses in DONE, `read_data` = 0, memory is unchanged.
- Request held high across DONE.
  - Exactly one access occurs; the next access starts in the following IDLE cycle.
  - Address `DEPTH*4+0x10` aliases to 0x10.
- `reset` driven low in the second ACCESS cycle of an SW.
  - `busywait` drops to 0 asynchronously and the target word is unchanged.
